// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath bundle for the multicycle controller
//
// Purpose: groups the instruction fields, datapath status and every control
// output of multicycle_control into one bundle.
//   master : the controller (drives strobes, selects, state, fault)
//   slave  : the datapath/memory side (drives opcode, funct3, alu_zero, mem_ready)
// Signals:
//   opcode[6:0], funct3[2:0]  instruction register fields
//   alu_zero, mem_ready       datapath / memory status
//   mem_read, mem_write       memory requests
//   ir_write, pc_write, reg_write  write strobes
//   pc_src, alu_src_a[1:0], alu_src_b[1:0], ALUop[1:0], mem_to_reg  selects
//   state[2:0], fault         current state and sticky error
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       mem_ready;

  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ALUop;
  logic       mem_to_reg;
  logic [2:0] state;
  logic       fault;

  modport master (
    input  opcode, funct3, alu_zero, mem_ready,
    output mem_read, mem_write, ir_write, pc_write, reg_write, pc_src,
           alu_src_a, alu_src_b, ALUop, mem_to_reg, state, fault
  );

  modport slave (
    output opcode, funct3, alu_zero, mem_ready,
    input  mem_read, mem_write, ir_write, pc_write, reg_write, pc_src,
           alu_src_a, alu_src_b, ALUop, mem_to_reg, state, fault
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V style control FSM with memory wait timeout
//
// Purpose: sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for R-type,
// I-ALU, load, store and branch instructions. Illegal opcodes and memory
// waits longer than WAIT_LIMIT cycles land in a sticky FAULT state that only
// reset leaves.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; all outputs are 0 while low
//   bus    multicycle_control_if.master (instruction fields and status in,
//          control strobes, selects, state and fault out)
module multicycle_control #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_RTYPE  = 3'd1,
    C_IALU   = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5
  } class_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The count value seen during the last allowed waiting cycle.
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t     r_state;
  class_t     r_cls;
  logic [7:0] r_wait_cnt;

  state_t     w_next;
  class_t     w_dec_cls;
  logic       w_timeout;
  logic       w_taken;
  logic       w_waiting;

  // Instruction class decode; branch funct3 010/011 have no meaning.
  always_comb begin
    w_dec_cls = C_NONE;
    case (bus.opcode)
      OP_RTYPE:  w_dec_cls = C_RTYPE;
      OP_IALU:   w_dec_cls = C_IALU;
      OP_LOAD:   w_dec_cls = C_LOAD;
      OP_STORE:  w_dec_cls = C_STORE;
      OP_BRANCH: if (bus.funct3[2:1] != 2'b01) w_dec_cls = C_BRANCH;
      default:   w_dec_cls = C_NONE;
    endcase
  end

  // funct3[2] selects the lt/ge family and funct3[0] inverts the sense, so
  // one XOR chain covers beq/bne/blt/bge/bltu/bgeu given the ALU zero flag.
  assign w_taken   = bus.alu_zero ^ bus.funct3[0] ^ bus.funct3[2];
  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
  // A ready in the same cycle always beats the timeout.
  assign w_timeout = !bus.mem_ready && (r_wait_cnt == LIMIT_M1);

  always_comb begin
    w_next = S_FAULT;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)   w_next = S_DECODE;
        else if (w_timeout)  w_next = S_FAULT;
        else                 w_next = S_FETCH;
      end
      S_DECODE: begin
        w_next = (w_dec_cls == C_NONE) ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        case (r_cls)
          C_RTYPE, C_IALU:  w_next = S_WB;
          C_LOAD, C_STORE:  w_next = S_MEM;
          C_BRANCH:         w_next = S_FETCH;
          default:          w_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)   w_next = (r_cls == C_LOAD) ? S_WB : S_FETCH;
        else if (w_timeout)  w_next = S_FAULT;
        else                 w_next = S_MEM;
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_cls      <= C_NONE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Class is captured once so EXEC/MEM/WB do not depend on opcode
      // staying put after the IR has been written.
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      if ((w_next == S_FETCH || w_next == S_MEM) && (w_next != r_state))
        r_wait_cnt <= '0;
      else if (w_waiting && !bus.mem_ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Outputs decode straight from the state so same-cycle handshakes
  // (IR/PC write on mem_ready) work; everything is held at 0 during reset.
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.ALUop      = 2'b00;
    bus.mem_to_reg = 1'b0;
    bus.fault      = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b10;
        end
        S_EXEC: begin
          bus.alu_src_a = 2'b01;
          case (r_cls)
            C_RTYPE: begin
              bus.alu_src_b = 2'b00;
              bus.ALUop     = 2'b10;
            end
            C_IALU: begin
              bus.alu_src_b = 2'b10;
              bus.ALUop     = 2'b11;
            end
            C_LOAD, C_STORE: begin
              bus.alu_src_b = 2'b10;
              bus.ALUop     = 2'b00;
            end
            C_BRANCH: begin
              bus.alu_src_b = 2'b00;
              bus.ALUop     = 2'b01;
              bus.pc_write  = w_taken;
              bus.pc_src    = w_taken;
            end
            default: bus.alu_src_a = 2'b00;
          endcase
        end
        S_MEM: begin
          bus.mem_read  = (r_cls == C_LOAD);
          bus.mem_write = (r_cls == C_STORE);
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (r_cls == C_LOAD);
        end
        default: bus.fault = 1'b1;
      endcase
    end
  end

  assign bus.state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.WAIT_LIMIT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {state, fault, mem_read, mem_write, ir_write, pc_write, reg_write, pc_src,
  //  alu_src_a, alu_src_b, ALUop, mem_to_reg}
  logic [16:0] obs;
  assign obs = {bus.state, bus.fault, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.pc_write, bus.reg_write, bus.pc_src, bus.alu_src_a,
                bus.alu_src_b, bus.ALUop, bus.mem_to_reg};

  localparam logic [16:0] E_ZERO = 17'd0;
  localparam logic [16:0] E_FW  = {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] E_FR  = {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] E_DEC = {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_EXR = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] E_EXI = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b11, 1'b0};
  localparam logic [16:0] E_EXM = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_BRN = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [16:0] E_BRT = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [16:0] E_MLD = {3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MST = {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_WBA = {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_WBL = {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] E_FLT = {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JL = 7'b1101111;

  typedef struct packed {
    logic        rdy;
    logic        zero;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [16:0] exp;
  } row_t;

  row_t        rows[$];
  logic [16:0] sb_q[$];

  task automatic add(input logic r, input logic z, input logic [6:0] op,
                     input logic [2:0] f3, input logic [16:0] e);
    row_t t;
    t.rdy = r; t.zero = z; t.op = op; t.f3 = f3; t.exp = e;
    rows.push_back(t);
  endtask

  // Drives one cycle's inputs (caller sits just after a rising edge), records
  // the expected outputs, and moves to the sampling point.
  task automatic drive_cycle(input row_t r);
    bus.mem_ready = r.rdy;
    bus.alu_zero  = r.zero;
    bus.opcode    = r.op;
    bus.funct3    = r.f3;
    sb_q.push_back(r.exp);
    @(negedge clk);
  endtask

  // Holds reset over two edges and releases just after a rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    bus.opcode = OP_R; bus.funct3 = 3'd0; bus.alu_zero = 1'b1; bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    e = E_ZERO;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_async got %b expected %b", obs, e); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held got %b expected %b", obs, e); end
  endtask

  task automatic test_rtype();
    logic [16:0] e;
    rows.delete();
    apply_reset();
    add(1, 0, OP_R, 3'd0, E_FR);
    add(1, 0, OP_R, 3'd0, E_DEC);
    add(1, 0, OP_R, 3'd0, E_EXR);
    add(1, 0, OP_R, 3'd0, E_WBA);
    add(0, 0, OP_R, 3'd0, E_FW);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rtype cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ialu_store();
    logic [16:0] e;
    rows.delete();
    apply_reset();
    add(1, 0, OP_I,  3'd0, E_FR);
    add(1, 0, OP_I,  3'd0, E_DEC);
    add(1, 0, OP_I,  3'd0, E_EXI);
    add(1, 0, OP_I,  3'd0, E_WBA);
    add(1, 0, OP_I,  3'd0, E_FR);
    add(1, 0, OP_ST, 3'd2, E_DEC);
    add(1, 0, OP_ST, 3'd2, E_EXM);
    add(1, 0, OP_ST, 3'd2, E_MST);
    add(0, 0, OP_ST, 3'd2, E_FW);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL ialu_store cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] e;
    rows.delete();
    apply_reset();
    add(1, 0, OP_LD, 3'd2, E_FR);
    add(0, 0, OP_LD, 3'd2, E_DEC);
    add(0, 0, OP_LD, 3'd2, E_EXM);
    add(0, 0, OP_LD, 3'd2, E_MLD);
    add(0, 0, OP_LD, 3'd2, E_MLD);
    add(0, 0, OP_LD, 3'd2, E_MLD);
    add(1, 0, OP_LD, 3'd2, E_MLD);
    add(0, 0, OP_LD, 3'd2, E_WBL);
    add(0, 0, OP_LD, 3'd2, E_FW);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL load_wait cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e;
    rows.delete();
    apply_reset();
    add(1, 1, OP_BR, 3'b101, E_FR);
    add(1, 1, OP_BR, 3'b101, E_DEC);
    add(1, 1, OP_BR, 3'b101, E_BRT);
    add(1, 0, OP_BR, 3'b101, E_FR);
    add(1, 0, OP_BR, 3'b101, E_DEC);
    add(1, 0, OP_BR, 3'b101, E_BRN);
    add(1, 1, OP_BR, 3'b101, E_FR);
    add(1, 1, OP_BR, 3'b000, E_DEC);
    add(1, 1, OP_BR, 3'b000, E_BRT);
    add(1, 0, OP_BR, 3'b000, E_FR);
    add(1, 0, OP_R,  3'b000, E_DEC);
    add(1, 0, OP_R,  3'b000, E_EXR);
    add(1, 0, OP_R,  3'b000, E_WBA);
    add(0, 0, OP_R,  3'b000, E_FW);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL back_to_back cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [16:0] e;
    rows.delete();
    apply_reset();
    add(1, 0, OP_JL, 3'd0, E_FR);
    add(1, 0, OP_JL, 3'd0, E_DEC);
    add(1, 0, OP_JL, 3'd0, E_FLT);
    add(1, 1, OP_R,  3'd0, E_FLT);
    add(0, 1, OP_R,  3'd0, E_FLT);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL illegal_op cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    e = E_ZERO;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL fault_reset got %b expected %b", obs, e); end
    rows.delete();
    apply_reset();
    add(1, 0, OP_BR, 3'b010, E_FR);
    add(1, 0, OP_BR, 3'b010, E_DEC);
    add(1, 0, OP_BR, 3'b010, E_FLT);
    add(1, 0, OP_BR, 3'b000, E_FLT);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL illegal_branch cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [16:0] e;
    rows.delete();
    apply_reset();
    for (int k = 0; k < 15; k++) add(0, 0, OP_R, 3'd0, E_FW);
    add(0, 0, OP_R, 3'd0, E_FLT);
    add(1, 0, OP_R, 3'd0, E_FLT);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
    rows.delete();
    apply_reset();
    for (int k = 0; k < 14; k++) add(0, 0, OP_R, 3'd0, E_FW);
    add(1, 0, OP_R, 3'd0, E_FR);
    add(1, 0, OP_R, 3'd0, E_DEC);
    add(1, 0, OP_R, 3'd0, E_EXR);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout_edge cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [16:0] e;
    rows.delete();
    apply_reset();
    add(1, 0, OP_ST, 3'd2, E_FR);
    add(1, 0, OP_ST, 3'd2, E_DEC);
    add(1, 0, OP_ST, 3'd2, E_EXM);
    add(0, 0, OP_ST, 3'd2, E_MST);
    foreach (rows[i]) begin
      drive_cycle(rows[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL store_wait cyc %0d got %b expected %b", i, obs, e); end
      @(posedge clk); #1;
    end
    #1;
    e = E_MST;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mem_write_held got %b expected %b", obs, e); end
    rst_n = 1'b0;
    #1;
    e = E_ZERO;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mid_mem_reset got %b expected %b", obs, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    e = E_FW;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL after_release got %b expected %b", obs, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_ialu_store();
    test_load_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
